// File: rtl/log_rs_scheduler.sv
// log_rs_scheduler: reservation station in front of the logical unit.
// Buffers dispatched logical ops, wakes missing operands from the CDB and
// issues the lowest-index ready entry over a valid/ready handshake.
// Ports: i_clk/i_rst (async active-high), dispatch (i_dispatch_*,
// o_dispatch_ready), CDB snoop (i_cdb_*), issue (o_issue_*, i_issue_ready).
// Optional macro LOG_RS_CDB_BYPASS_EN: same-cycle CDB-to-issue bypass.

package log_rs_pkg;
   typedef enum logic [3:0] {
      LOG_AND    = 4'd0,
      LOG_OR     = 4'd1,
      LOG_XOR    = 4'd2,
      LOG_NAND   = 4'd3,
      LOG_NOR    = 4'd4,
      LOG_EQV    = 4'd5,
      LOG_ANDC   = 4'd6,
      LOG_ORC    = 4'd7,
      LOG_EXTSB  = 4'd8,
      LOG_EXTSH  = 4'd9,
      LOG_CNTLZW = 4'd10
   } log_op_e;

   typedef struct packed {
      log_op_e opcode;
      logic    alter_cr0;
   } log_decode_t;

   localparam int LOG_DECODE_W = $bits(log_decode_t);
endpackage

module log_rs_scheduler
   import log_rs_pkg::*;
#(
   parameter int RS_DEPTH    = 4,
   parameter int RS_ID_WIDTH = 5,
   parameter int RS_OFFSET   = 0
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_dispatch_valid,
   output logic                    o_dispatch_ready,
   input  logic [31:0]             i_dispatch_op1,
   input  logic [31:0]             i_dispatch_op2,
   input  logic                    i_dispatch_op1_rdy,
   input  logic                    i_dispatch_op2_rdy,
   input  logic [RS_ID_WIDTH-1:0]  i_dispatch_op1_tag,
   input  logic [RS_ID_WIDTH-1:0]  i_dispatch_op2_tag,
   input  logic [LOG_DECODE_W-1:0] i_dispatch_control,
   input  logic [4:0]              i_dispatch_reg_addr,
   input  logic                    i_cdb_valid,
   input  logic [RS_ID_WIDTH-1:0]  i_cdb_rs_id,
   input  logic [31:0]             i_cdb_data,
   output logic                    o_issue_valid,
   input  logic                    i_issue_ready,
   output logic [RS_ID_WIDTH-1:0]  o_issue_rs_id,
   output logic [4:0]              o_issue_reg_addr,
   output logic [31:0]             o_issue_op1,
   output logic [31:0]             o_issue_op2,
   output logic [LOG_DECODE_W-1:0] o_issue_control
);

   localparam int IDX_W = $clog2(RS_DEPTH);

   logic [RS_DEPTH-1:0]     r_busy;
   logic [RS_DEPTH-1:0]     r_op1_rdy;
   logic [RS_DEPTH-1:0]     r_op2_rdy;
   logic [31:0]             r_op1     [RS_DEPTH];
   logic [31:0]             r_op2     [RS_DEPTH];
   logic [RS_ID_WIDTH-1:0]  r_op1_tag [RS_DEPTH];
   logic [RS_ID_WIDTH-1:0]  r_op2_tag [RS_DEPTH];
   logic [LOG_DECODE_W-1:0] r_ctrl    [RS_DEPTH];
   logic [4:0]              r_rd      [RS_DEPTH];

   logic [RS_DEPTH-1:0] w_hit1;
   logic [RS_DEPTH-1:0] w_hit2;
   logic [RS_DEPTH-1:0] w_cand;
   logic [IDX_W-1:0]    w_free_idx;
   logic [IDX_W-1:0]    w_sel_idx;
   logic                w_disp_fire;
   logic                w_issue_fire;
   logic                w_d1_hit;
   logic                w_d2_hit;

   // Only registered busy bits: issue_ready never reaches dispatch_ready.
   assign o_dispatch_ready = ~&r_busy;
   assign o_issue_valid    = |w_cand;
   assign w_disp_fire      = i_dispatch_valid & o_dispatch_ready;
   assign w_issue_fire     = o_issue_valid & i_issue_ready;

   // Operand arriving on the CDB in the very cycle it is dispatched.
   assign w_d1_hit = i_cdb_valid & ~i_dispatch_op1_rdy &
                     (i_dispatch_op1_tag == i_cdb_rs_id);
   assign w_d2_hit = i_cdb_valid & ~i_dispatch_op2_rdy &
                     (i_dispatch_op2_tag == i_cdb_rs_id);

   always_comb begin
      w_hit1 = '0;
      w_hit2 = '0;
      w_cand = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         w_hit1[i] = i_cdb_valid & r_busy[i] & ~r_op1_rdy[i] &
                     (r_op1_tag[i] == i_cdb_rs_id);
         w_hit2[i] = i_cdb_valid & r_busy[i] & ~r_op2_rdy[i] &
                     (r_op2_tag[i] == i_cdb_rs_id);
`ifdef LOG_RS_CDB_BYPASS_EN
         w_cand[i] = r_busy[i] & (r_op1_rdy[i] | w_hit1[i]) &
                     (r_op2_rdy[i] | w_hit2[i]);
`else
         w_cand[i] = r_busy[i] & r_op1_rdy[i] & r_op2_rdy[i];
`endif
      end
   end

   // Descending scans so the lowest index wins.
   always_comb begin
      w_free_idx = '0;
      w_sel_idx  = '0;
      for (int i = RS_DEPTH - 1; i >= 0; i--) begin
         if (!r_busy[i]) w_free_idx = IDX_W'(i);
         if (w_cand[i])  w_sel_idx  = IDX_W'(i);
      end
   end

   always_comb begin
      o_issue_rs_id    = '0;
      o_issue_reg_addr = '0;
      o_issue_op1      = '0;
      o_issue_op2      = '0;
      o_issue_control  = '0;
      if (o_issue_valid) begin
         o_issue_rs_id    = RS_ID_WIDTH'(RS_OFFSET) +
                            RS_ID_WIDTH'(w_sel_idx);
         o_issue_reg_addr = r_rd[w_sel_idx];
         o_issue_op1      = r_op1[w_sel_idx];
         o_issue_op2      = r_op2[w_sel_idx];
         o_issue_control  = r_ctrl[w_sel_idx];
`ifdef LOG_RS_CDB_BYPASS_EN
         if (!r_op1_rdy[w_sel_idx]) o_issue_op1 = i_cdb_data;
         if (!r_op2_rdy[w_sel_idx]) o_issue_op2 = i_cdb_data;
`endif
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_busy    <= '0;
         r_op1_rdy <= '0;
         r_op2_rdy <= '0;
         for (int i = 0; i < RS_DEPTH; i++) begin
            r_op1[i]     <= '0;
            r_op2[i]     <= '0;
            r_op1_tag[i] <= '0;
            r_op2_tag[i] <= '0;
            r_ctrl[i]    <= '0;
            r_rd[i]      <= '0;
         end
      end else begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            if (w_disp_fire && w_free_idx == IDX_W'(i)) begin
               r_busy[i]    <= 1'b1;
               r_op1[i]     <= w_d1_hit ? i_cdb_data : i_dispatch_op1;
               r_op2[i]     <= w_d2_hit ? i_cdb_data : i_dispatch_op2;
               r_op1_rdy[i] <= i_dispatch_op1_rdy | w_d1_hit;
               r_op2_rdy[i] <= i_dispatch_op2_rdy | w_d2_hit;
               r_op1_tag[i] <= i_dispatch_op1_tag;
               r_op2_tag[i] <= i_dispatch_op2_tag;
               r_ctrl[i]    <= i_dispatch_control;
               r_rd[i]      <= i_dispatch_reg_addr;
            end else begin
               if (w_issue_fire && w_sel_idx == IDX_W'(i))
                  r_busy[i] <= 1'b0;
               if (w_hit1[i]) begin
                  r_op1[i]     <= i_cdb_data;
                  r_op1_rdy[i] <= 1'b1;
               end
               if (w_hit2[i]) begin
                  r_op2[i]     <= i_cdb_data;
                  r_op2_rdy[i] <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_log_rs_scheduler.sv
// tb_log_rs_scheduler: directed table-driven bench for log_rs_scheduler.
// Works in both the default build and with LOG_RS_CDB_BYPASS_EN defined.

module tb_log_rs_scheduler;
   import log_rs_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        d_valid = 1'b0;
   logic        d_ready;
   logic [31:0] d_op1 = '0, d_op2 = '0;
   logic        d_r1 = 1'b0, d_r2 = 1'b0;
   logic [4:0]  d_t1 = '0, d_t2 = '0;
   logic [4:0]  d_ctrl = '0;
   logic [4:0]  d_rd = '0;
   logic        c_valid = 1'b0;
   logic [4:0]  c_id = '0;
   logic [31:0] c_data = '0;
   logic        is_valid;
   logic        is_ready = 1'b0;
   logic [4:0]  is_id;
   logic [4:0]  is_rd;
   logic [31:0] is_op1, is_op2;
   logic [4:0]  is_ctrl;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   log_rs_scheduler #(
      .RS_DEPTH(4), .RS_ID_WIDTH(5), .RS_OFFSET(0)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_dispatch_valid(d_valid), .o_dispatch_ready(d_ready),
      .i_dispatch_op1(d_op1), .i_dispatch_op2(d_op2),
      .i_dispatch_op1_rdy(d_r1), .i_dispatch_op2_rdy(d_r2),
      .i_dispatch_op1_tag(d_t1), .i_dispatch_op2_tag(d_t2),
      .i_dispatch_control(d_ctrl), .i_dispatch_reg_addr(d_rd),
      .i_cdb_valid(c_valid), .i_cdb_rs_id(c_id), .i_cdb_data(c_data),
      .o_issue_valid(is_valid), .i_issue_ready(is_ready),
      .o_issue_rs_id(is_id), .o_issue_reg_addr(is_rd),
      .o_issue_op1(is_op1), .o_issue_op2(is_op2),
      .o_issue_control(is_ctrl)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Called just after a negedge; returns at the negedge after the write.
   task automatic disp(input logic [31:0] o1, input logic r1,
                       input logic [4:0] t1, input logic [31:0] o2,
                       input logic r2, input logic [4:0] t2,
                       input logic [4:0] ctl, input logic [4:0] rd);
      d_valid = 1'b1;
      d_op1 = o1; d_r1 = r1; d_t1 = t1;
      d_op2 = o2; d_r2 = r2; d_t2 = t2;
      d_ctrl = ctl; d_rd = rd;
      @(posedge clk);
      @(negedge clk);
      d_valid = 1'b0;
   endtask

   typedef struct {
      logic [31:0] op1;
      logic [31:0] op2;
      logic        op2_rdy;
      logic [4:0]  op2_tag;
      logic        cdb_v;
      logic [4:0]  cdb_id;
      logic [31:0] cdb_d;
      logic [4:0]  ctrl;
      logic [4:0]  rd;
      logic [31:0] e_op1;
      logic [31:0] e_op2;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{32'hF0F0F0F0, 32'h0FF0FF00, 1'b1, 5'd0, 1'b0, 5'd0,
                  32'h0, {LOG_AND, 1'b0}, 5'd3,
                  32'hF0F0F0F0, 32'h0FF0FF00};
      vecs[1] = '{32'h00000001, 32'hDEADBEEF, 1'b0, 5'd9, 1'b1, 5'd9,
                  32'hAAAA5555, {LOG_OR, 1'b1}, 5'd7,
                  32'h00000001, 32'hAAAA5555};
      vecs[2] = '{32'h13579BDF, 32'h2468ACE0, 1'b1, 5'd9, 1'b1, 5'd9,
                  32'h11111111, {LOG_XOR, 1'b0}, 5'd31,
                  32'h13579BDF, 32'h2468ACE0};
      vecs[3] = '{32'h00010000, 32'h00000000, 1'b1, 5'd0, 1'b0, 5'd0,
                  32'h0, {LOG_CNTLZW, 1'b1}, 5'd1,
                  32'h00010000, 32'h00000000};
      vecs[4] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 5'd4, 1'b1, 5'd5,
                  32'h99999999, {LOG_NAND, 1'b0}, 5'd12,
                  32'hFFFFFFFF, 32'h00000000};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_dready", 32'(d_ready), 32'd1);
      chk("rst_ivalid", 32'(is_valid), 32'd0);
      chk("rst_op1", is_op1, 32'd0);
      chk("rst_id", 32'(is_id), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Table: dispatch, check issue next cycle, accepted at once
      is_ready = 1'b1;
      for (int v = 0; v < 5; v++) begin
         c_valid = vecs[v].cdb_v;
         c_id    = vecs[v].cdb_id;
         c_data  = vecs[v].cdb_d;
         disp(vecs[v].op1, 1'b1, 5'd0, vecs[v].op2, vecs[v].op2_rdy,
              vecs[v].op2_tag, vecs[v].ctrl, vecs[v].rd);
         c_valid = 1'b0;
         chk($sformatf("v%0d_valid", v), 32'(is_valid), 32'd1);
         chk($sformatf("v%0d_op1", v), is_op1, vecs[v].e_op1);
         chk($sformatf("v%0d_op2", v), is_op2, vecs[v].e_op2);
         chk($sformatf("v%0d_id", v), 32'(is_id), 32'd0);
         chk($sformatf("v%0d_ctrl", v), 32'(is_ctrl), 32'(vecs[v].ctrl));
         chk($sformatf("v%0d_rd", v), 32'(is_rd), 32'(vecs[v].rd));
         chk($sformatf("v%0d_dready", v), 32'(d_ready), 32'd1);
         @(negedge clk);
         chk($sformatf("v%0d_drain", v), 32'(is_valid), 32'd0);
      end

      // Wakeup on tag 7 three cycles after dispatch
      disp(32'h0, 1'b0, 5'd7, 32'h00FF00FF, 1'b1, 5'd0,
           {LOG_AND, 1'b0}, 5'd4);
      for (int c = 0; c < 3; c++) begin
         chk("t7_wait", 32'(is_valid), 32'd0);
         @(negedge clk);
      end
      c_valid = 1'b1; c_id = 5'd7; c_data = 32'h12345678;
`ifdef LOG_RS_CDB_BYPASS_EN
      chk("t7_bypass_valid", 32'(is_valid), 32'd1);
      chk("t7_bypass_op1", is_op1, 32'h12345678);
      @(negedge clk);
      c_valid = 1'b0;
`else
      chk("t7_no_bypass", 32'(is_valid), 32'd0);
      @(negedge clk);
      c_valid = 1'b0;
      chk("t7_valid", 32'(is_valid), 32'd1);
      chk("t7_op1", is_op1, 32'h12345678);
      chk("t7_op2", is_op2, 32'h00FF00FF);
      @(negedge clk);
`endif
      chk("t7_drain", 32'(is_valid), 32'd0);

      // Fill all entries pending on tag 3
      is_ready = 1'b0;
      for (int k = 0; k < 4; k++)
         disp(32'h0, 1'b0, 5'd3, 32'(k), 1'b1, 5'd0,
              {LOG_OR, 1'b0}, 5'(k + 8));
      chk("full_dready", 32'(d_ready), 32'd0);
      chk("full_ivalid", 32'(is_valid), 32'd0);
      is_ready = 1'b1;
      chk("full_dready_ir", 32'(d_ready), 32'd0);
      c_valid = 1'b1; c_id = 5'd3; c_data = 32'hCAFE0003;
`ifdef LOG_RS_CDB_BYPASS_EN
      chk("fill_id0", 32'(is_id), 32'd0);
      chk("fill_op1_0", is_op1, 32'hCAFE0003);
      @(negedge clk);
      c_valid = 1'b0;
      for (int k = 1; k < 4; k++) begin
`else
      @(negedge clk);
      c_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
`endif
         chk($sformatf("fill_id%0d", k), 32'(is_id), 32'(k));
         chk($sformatf("fill_op1_%0d", k), is_op1, 32'hCAFE0003);
         chk($sformatf("fill_op2_%0d", k), is_op2, 32'(k));
         chk($sformatf("fill_dready%0d", k), 32'(d_ready),
             (k == 0) ? 32'd0 : 32'd1);
         @(negedge clk);
      end
      chk("fill_drain", 32'(is_valid), 32'd0);

      // Stall with entry 1 ready; entry 0 wakes later and displaces it
      is_ready = 1'b0;
      disp(32'h0, 1'b0, 5'd11, 32'h00000022, 1'b1, 5'd0,
           {LOG_EQV, 1'b0}, 5'd2);
      disp(32'h00000055, 1'b1, 5'd0, 32'h00000066, 1'b1, 5'd0,
           {LOG_NOR, 1'b1}, 5'd9);
      for (int c = 0; c < 5; c++) begin
         if (c == 3) c_valid = 1'b0;
         chk($sformatf("stall%0d_valid", c), 32'(is_valid), 32'd1);
         if (c < 3) begin
            chk($sformatf("stall%0d_id", c), 32'(is_id), 32'd1);
            chk($sformatf("stall%0d_op1", c), is_op1, 32'h00000055);
            chk($sformatf("stall%0d_rd", c), 32'(is_rd), 32'd9);
         end else begin
            chk($sformatf("stall%0d_id", c), 32'(is_id), 32'd0);
            chk($sformatf("stall%0d_op1", c), is_op1, 32'h0B0B0B0B);
            chk($sformatf("stall%0d_op2", c), is_op2, 32'h00000022);
         end
         if (c == 2) begin
            c_valid = 1'b1; c_id = 5'd11; c_data = 32'h0B0B0B0B;
         end
         @(negedge clk);
      end
      is_ready = 1'b1;
      @(negedge clk);
      chk("stall_next_id", 32'(is_id), 32'd1);
      @(negedge clk);
      chk("stall_drain", 32'(is_valid), 32'd0);

      // Asynchronous reset mid-cycle with three busy entries
      is_ready = 1'b0;
      disp(32'h1, 1'b1, 5'd0, 32'h2, 1'b1, 5'd0, {LOG_AND, 1'b0}, 5'd5);
      disp(32'h3, 1'b1, 5'd0, 32'h4, 1'b1, 5'd0, {LOG_AND, 1'b0}, 5'd6);
      disp(32'h0, 1'b0, 5'd20, 32'h5, 1'b1, 5'd0, {LOG_AND, 1'b0}, 5'd7);
      chk("prerst_valid", 32'(is_valid), 32'd1);
      chk("prerst_dready", 32'(d_ready), 32'd1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(is_valid), 32'd0);
      chk("arst_dready", 32'(d_ready), 32'd1);
      chk("arst_op1", is_op1, 32'd0);
      chk("arst_rd", 32'(is_rd), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      c_valid = 1'b1; c_id = 5'd20; c_data = 32'h77777777;
      is_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("postrst%0d_valid", c), 32'(is_valid), 32'd0);
         @(negedge clk);
      end
      c_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/log_rs_scheduler.md
# log_rs_scheduler

Reservation-station scheduler in front of the logical execution unit. It buffers dispatched logical ops (and/or/xor/nand/nor/eqv/andc/orc/extsb/extsh/cntlzw) whose source operands may still be in flight. It snoops the common data bus (CDB) for missing operands and issues ready entries to the logical unit over a valid/ready handshake. Each entry carries a unique rs_id, which the unit returns with its result.

## Interface
Parameters:
- RS_DEPTH, 4, number of entries (2..8)
- RS_ID_WIDTH, 5, width of rs_id and operand tags (global producer IDs)
- RS_OFFSET, 0, rs_id of entry 0; entry i owns rs_id RS_OFFSET+i

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  clock
  - rst  in  1  asynchronous active-high reset
- Dispatch interface:
  - dispatch_valid  in  1  new op offered
  - dispatch_ready  out  1  a free entry exists
  - dispatch_op1, dispatch_op2  in  32 each  operand values, meaningful only when the matching ready bit is 1
  - dispatch_op1_rdy, dispatch_op2_rdy  in  1 each  operand value is valid
  - dispatch_op1_tag, dispatch_op2_tag  in  RS_ID_WIDTH each  producer rs_id when the operand is not ready
  - dispatch_control  in  log_decode_t  opcode and alter_CR0
  - dispatch_reg_addr  in  5  destination GPR
- CDB snoop interface:
  - cdb_valid  in  1  result broadcast
  - cdb_rs_id  in  RS_ID_WIDTH  producer of the broadcast
  - cdb_data  in  32  broadcast value
- Issue interface:
  - issue_valid  out  1  op presented to the logical unit
  - issue_ready  in  1  the logical unit accepts (its input_ready)
  - issue_rs_id  out  RS_ID_WIDTH  rs_id of the issued entry
  - issue_reg_addr  out  5  destination GPR
  - issue_op1, issue_op2  out  32 each  operands
  - issue_control  out  log_decode_t  opcode

## Operation
Per-entry registered state:
- busy
- op1/op2 value
- op1/op2 ready
- op1/op2 tag
- control
- reg_addr

Dispatch:
- dispatch_ready = OR over entries of ~busy, computed from registered state only.
- On dispatch_valid & dispatch_ready, the lowest-index free entry is written and busy is set to 1.
- If a dispatched operand is not ready and cdb_valid & cdb_rs_id == its tag in the same cycle, the CDB data is captured and the operand is marked ready.

Wakeup:
- Every cycle, each busy entry with a not-ready operand whose tag equals cdb_rs_id (with cdb_valid) latches cdb_data and sets that operand's ready bit.
- Both operands may wake on the same broadcast.
- Only ready=0 operands compare; a ready operand never takes CDB data.

Select:
- Candidate = busy & op1 ready & op2 ready.
- The lowest-index candidate is presented on the issue port.
- issue_valid = 1 when any candidate exists.
- All issue payload outputs are 0 when issue_valid = 0.

Issue:
- On issue_valid & issue_ready, the selected entry's busy is cleared at the clock edge.
- Selection is recomputed every cycle. A lower-index entry becoming ready may displace the presented one before acceptance. The logical unit samples only on handshake, so this is legal.

Simultaneous events:
- An issue and a dispatch in the same cycle are both honoured.
- The entry freed by an issue is not visible to dispatch_ready until the next cycle.
- cntlzw/extsb/extsh ignore op2: the dispatcher presents dispatch_op2_rdy = 1, and the scheduler applies no special case.

## Timing
- Reset (asynchronous, any time): all busy and ready bits are cleared, and values/tags are set to 0.
- Output values while rst = 1 and after release:
  - dispatch_ready = 1
  - issue_valid = 0
  - all issue payload outputs = 0
- Reset mid-operation discards all entries; no issue completes in the reset cycle.
- Dispatch with both operands ready: the entry is written at edge N, and issue_valid is asserted in cycle N+1 (1-cycle latency).
- Wakeup without bypass: the CDB hit is latched at edge N, and the entry is issue-eligible from cycle N+1.
- Throughput: one dispatch and one issue per cycle.
- issue_* outputs are combinational from the registered entry state; issue_ready must not combinationally feed dispatch_ready.
- Full condition: all RS_DEPTH entries busy → dispatch_ready = 0, regardless of issue_ready.

## Configuration
- LOG_RS_CDB_BYPASS_EN defined:
  - A busy entry whose last missing operand(s) match the CDB in the current cycle counts as a candidate in that same cycle.
  - The missing operand value is muxed from cdb_data onto issue_op1/issue_op2.
  - The wakeup-to-issue latency is 0 cycles.
  - If that bypassed entry is accepted, it is freed at the same edge.
- LOG_RS_CDB_BYPASS_EN undefined: the behaviour in Timing applies; wakeup-to-issue latency is 1 cycle, and no CDB-to-issue combinational path exists.

## Test plan
- Reset, then dispatch an and-op with op1 = 0xF0F0F0F0, op2 = 0x0FF0FF00, both ready, with issue_ready = 1 → issue_valid in the next cycle with op1/op2 unchanged, issue_rs_id = RS_OFFSET, and dispatch_ready stays 1.
- Dispatch an op with op1 pending on tag 7 and issue_ready = 1, then 3 cycles later cdb_valid with rs_id 7 and data 0x12345678:
  - without the macro: issue one cycle later with issue_op1 = 0x12345678;
  - with the macro: issue in the same cycle.
- Fill all 4 entries with ops pending on tag 3 while issue_ready = 0 → dispatch_ready = 0. Then broadcast tag 3 and raise issue_ready → entries issue in index order 0, 1, 2, 3, one per cycle; dispatch_ready returns to 1 after the first issue.
- Dispatch with op2 tag 9 in the same cycle as cdb_valid rs_id 9, data 0xAAAA5555 → the entry captures 0xAAAA5555, with no further wait.
- Hold issue_ready = 0 for 5 cycles with entry 1 ready → issue_valid and the payload stay stable. Entry 0 becomes ready in cycle 3 → the presented op switches to entry 0.
- Assert rst asynchronously mid-cycle with 3 busy entries → issue_valid drops immediately and dispatch_ready = 1; no CDB broadcast afterwards causes an issue.
